// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions for the serial transmit path and the
// receive-side syndrome logic.
//   DATA_W / CW_W       : nibble and codeword widths
//   tx_state_t          : serial transmitter states
//   hamming74_encode()  : nibble -> codeword {d4,d3,d2,p3,d1,p2,p1}
package hamming_pkg;
   localparam int DATA_W = 4;
   localparam int CW_W   = 7;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   function automatic logic [CW_W-1:0] hamming74_encode(input logic [DATA_W-1:0] d);
      logic p1, p2, p3;
      p1 = d[0] ^ d[1] ^ d[3];
      p2 = d[0] ^ d[2] ^ d[3];
      p3 = d[1] ^ d[2] ^ d[3];
      return {d[3], d[2], d[1], p3, d[0], p2, p1};
   endfunction
endpackage

// File: rtl/hamming74_encoder.sv
// Combinational Hamming(7,4) encoder.
//   data : input nibble, d1 = data[0] .. d4 = data[3]
//   cw   : codeword, cw[i] = position i+1
module hamming74_encoder
   import hamming_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   output logic [CW_W-1:0]   cw
);
   assign cw = hamming74_encode(data);
endmodule

// File: rtl/hamming_tx_serial.sv
// Hamming(7,4) serial transmitter. A nibble accepted over valid/ready is
// encoded and shifted out as a UART-style frame: start bit (0), seven
// codeword bits LSB first, stop bit (1), each bit BIT_CYCLES clocks long.
// Optional build macro HAMMING_ERR_INJECT_EN: the codeword position given on
// err_pos (1..7) is inverted at transfer time; 0 means no corruption.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   in_data    : nibble to send        in_valid : nibble valid
//   in_ready   : high in IDLE          err_pos  : position to corrupt
//   tx_line    : serial out, idle high busy     : frame in progress
//   done       : one-cycle end pulse   codeword : codeword of current/last frame
//
// state | meaning
// IDLE  | line high, ready for a nibble
// START | start bit, line low
// DATA  | codeword bits 0..6 on the line
// STOP  | stop bit, line high
module hamming_tx_serial
   import hamming_pkg::*;
#(
   parameter int BIT_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        err_pos,
   output logic              tx_line,
   output logic              busy,
   output logic              done,
   output logic [CW_W-1:0]   codeword
);
   localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

   tx_state_t        state_q, state_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [2:0]       idx_q, idx_d;
   logic [CW_W-1:0]  shift_q, shift_d;
   logic [CW_W-1:0]  cw_q, cw_d;
   logic             tx_line_q, tx_line_d;
   logic             done_q, done_d;

   logic [CW_W-1:0]  enc_cw;
   logic [CW_W-1:0]  err_mask;
   logic [CW_W-1:0]  cw_load;
   logic             bit_end;

   hamming74_encoder u_enc (
      .data (in_data),
      .cw   (enc_cw)
   );

`ifdef HAMMING_ERR_INJECT_EN
   always_comb begin
      err_mask = '0;
      if (err_pos != 3'd0) err_mask[err_pos - 3'd1] = 1'b1;
   end
`else
   logic unused_err_pos;
   assign unused_err_pos = ^err_pos;
   assign err_mask = '0;
`endif

   assign cw_load = enc_cw ^ err_mask;
   assign bit_end = (cyc_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      cw_d    = cw_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = START;
               cw_d    = cw_load;
               shift_d = cw_load;
               cyc_d   = '0;
               idx_d   = '0;
            end
         end
         START: begin
            if (bit_end) begin
               cyc_d   = '0;
               idx_d   = '0;
               state_d = DATA;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               cyc_d = '0;
               if (idx_q == 3'd6) begin
                  state_d = STOP;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  shift_d = shift_q >> 1;
               end
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               cyc_d   = '0;
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Line is registered from the next state so it changes with the state.
      case (state_d)
         START:   tx_line_d = 1'b0;
         DATA:    tx_line_d = shift_d[0];
         default: tx_line_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cyc_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         cw_q      <= '0;
         tx_line_q <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         cw_q      <= cw_d;
         tx_line_q <= tx_line_d;
         done_q    <= done_d;
      end
   end

   assign tx_line  = tx_line_q;
   assign done     = done_q;
   assign codeword = cw_q;
   assign busy     = (state_q != IDLE);
   assign in_ready = (state_q == IDLE);
endmodule

// File: tb/tb_hamming_tx_serial.sv
// Testbench for hamming_tx_serial: directed scenarios plus a randomized run,
// all checked every cycle against a frame-level behavioural model.
module tb_hamming_tx_serial;
   import hamming_pkg::*;

   localparam int BC    = 4;
   localparam int FRAME = 9 * BC;
`ifdef HAMMING_ERR_INJECT_EN
   localparam bit INJ = 1'b1;
`else
   localparam bit INJ = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic [3:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] err_pos;
   logic       tx_line;
   logic       busy;
   logic       done;
   logic [6:0] codeword;

   int vectors    = 0;
   int miscompares = 0;

   hamming_tx_serial #(.BIT_CYCLES(BC)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .err_pos  (err_pos),
      .tx_line  (tx_line),
      .busy     (busy),
      .done     (done),
      .codeword (codeword)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Position-based Hamming: data at positions 3,5,6,7; parity at 1,2,4
   // covers every position whose index shares that bit.
   function automatic logic [6:0] model_encode(input logic [3:0] d);
      logic [7:0] pos;
      pos    = '0;
      pos[3] = d[0];
      pos[5] = d[1];
      pos[6] = d[2];
      pos[7] = d[3];
      for (int k = 0; k < 3; k++) begin
         int p;
         p = 1 << k;
         for (int j = 3; j <= 7; j++)
            if ((j & p) != 0) pos[p] = pos[p] ^ pos[j];
      end
      return pos[7:1];
   endfunction

   function automatic logic [2:0] syndrome(input logic [6:0] cw);
      int s;
      s = 0;
      for (int p = 1; p <= 7; p++)
         if (cw[p-1]) s = s ^ p;
      return 3'(s);
   endfunction

   function automatic logic [6:0] model_load(input logic [3:0] d, input logic [2:0] ep);
      logic [6:0] cw;
      cw = model_encode(d);
      if (INJ && ep != 3'd0) cw[int'(ep) - 1] = ~cw[int'(ep) - 1];
      return cw;
   endfunction

   // Frame-level model: m_t = cycles since the transfer edge.
   bit         m_valid  = 1'b0;
   bit         m_active = 1'b0;
   bit         m_done   = 1'b0;
   int         m_t      = 0;
   logic [6:0] m_cw     = '0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_valid  = 1'b1;
         m_active = 1'b0;
         m_done   = 1'b0;
         m_cw     = '0;
      end else if (m_valid) begin
         if (!m_active && in_valid) begin
            m_active = 1'b1;
            m_t      = 0;
            m_done   = 1'b0;
            m_cw     = model_load(in_data, err_pos);
         end else if (m_active) begin
            m_t++;
            m_done = 1'b0;
            if (m_t == FRAME) begin
               m_active = 1'b0;
               m_done   = 1'b1;
            end
         end else begin
            m_done = 1'b0;
         end
      end
   end

   function automatic logic model_line();
      int k;
      if (!m_active) return 1'b1;
      k = m_t / BC;
      if (k == 0) return 1'b0;
      if (k <= 7) return m_cw[k-1];
      return 1'b1;
   endfunction

   always @(negedge clk) begin
      if (m_valid) begin
         logic [10:0] act, exp;
         act = {tx_line, busy, in_ready, done, codeword};
         exp = {model_line(), m_active, !m_active, m_done, m_cw};
         vectors++;
         if (act !== exp) begin
            miscompares++;
            $display("FAIL cycle_check @%0t: got tx=%b busy=%b rdy=%b done=%b cw=%h, expected tx=%b busy=%b rdy=%b done=%b cw=%h",
                     $time, act[10], act[9], act[8], act[7], act[6:0],
                     exp[10], exp[9], exp[8], exp[7], exp[6:0]);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Returns at the negedge of the first cycle after the transfer edge.
   task automatic send(input logic [3:0] d, input logic [2:0] ep);
      int n;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("send_ready", in_ready, 1);
      in_data  = d;
      err_pos  = ep;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 4'($urandom);
      err_pos  = 3'($urandom);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", done, 1);
   endtask

   initial begin
      logic [8:0] seq;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      err_pos  = '0;
      repeat (3) @(negedge clk);
      check("rst_tx_line",  tx_line,  1);
      check("rst_in_ready", in_ready, 1);
      check("rst_busy",     busy,     0);
      check("rst_done",     done,     0);
      check("rst_codeword", codeword, 7'h00);
      rst_n = 1'b1;
      @(negedge clk);

      // Model pins and encode sweep
      check("model_enc_0", model_encode(4'h0), 7'h00);
      check("model_enc_1", model_encode(4'h1), 7'h07);
      check("model_enc_f", model_encode(4'hF), 7'h7F);
      check("model_enc_b", model_encode(4'hB), 7'h55);
      check("model_enc_3", model_encode(4'h3), 7'h1E);
      check("model_enc_c", model_encode(4'hC), 7'h61);
      check("model_syn_45", syndrome(7'h45), 3'd5);
      for (int n = 0; n < 16; n++) begin
         check("pkg_encode", hamming74_encode(4'(n)), model_encode(4'(n)));
         check("syndrome_zero", syndrome(hamming74_encode(4'(n))), 3'd0);
      end

      // Single frame, literal line sequence
      seq = 9'h1AA;
      send(4'hB, 3'd0);
      check("frame_b_cw", codeword, 7'h55);
      for (int t = 0; t < FRAME; t++) begin
         check("frame_b_line", tx_line, seq[t / BC]);
         @(negedge clk);
      end
      check("frame_b_done_at_36", done, 1);
      check("frame_b_ready_done", in_ready, 1);
      @(negedge clk);
      check("frame_b_done_pulse", done, 0);

      // Back-to-back with in_valid held
      in_data  = 4'h3;
      err_pos  = 3'd0;
      in_valid = 1'b1;
      @(negedge clk);
      check("b2b_cw1", codeword, 7'h1E);
      in_data = 4'hC;
      wait_done();
      check("b2b_idle_line", tx_line, 1);
      check("b2b_idle_ready", in_ready, 1);
      @(negedge clk);
      check("b2b_busy2", busy, 1);
      check("b2b_start2", tx_line, 0);
      check("b2b_cw2", codeword, 7'h61);
      in_valid = 1'b0;
      wait_done();
      @(negedge clk);

      // Reset during DATA bit index 3
      send(4'h6, 3'd0);
      repeat (17) @(negedge clk);
      check("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_line",  tx_line,  1);
      check("mid_rst_ready", in_ready, 1);
      check("mid_rst_busy",  busy,     0);
      check("mid_rst_cw",    codeword, 7'h00);
      rst_n = 1'b1;
      @(negedge clk);
      send(4'h1, 3'd0);
      check("post_rst_cw", codeword, 7'h07);
      wait_done();
      @(negedge clk);

      // Error injection
`ifdef HAMMING_ERR_INJECT_EN
      send(4'hB, 3'd5);
      check("inj5_cw", codeword, 7'h45);
      check("inj5_syn", syndrome(codeword), 3'd5);
      wait_done();
      send(4'hB, 3'd0);
      check("inj0_cw", codeword, 7'h55);
      check("inj0_syn", syndrome(codeword), 3'd0);
      wait_done();
`else
      send(4'hB, 3'd5);
      check("noinj_cw", codeword, 7'h55);
      check("noinj_syn", syndrome(codeword), 3'd0);
      wait_done();
`endif
      @(negedge clk);

      // Randomized traffic with occasional resets
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         rst_n    = ($urandom_range(0, 399) != 0);
         in_valid = ($urandom_range(0, 3) == 0);
         in_data  = 4'($urandom);
         err_pos  = 3'($urandom);
      end
      rst_n    = 1'b1;
      in_valid = 1'b0;
      repeat (FRAME + 4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
